// File: rtl/usb_fifo_arbiter_pkg.sv
// Shared definitions for the USB TX FIFO packet arbiter: state encoding,
// source indices and a small helper for the round-robin pointer.
package usb_arb_pkg;

   // Arbiter FSM states
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // Source indices into the src_* vectors
   localparam int N_SRC     = 3;
   localparam int SRC_ADC   = 0;
   localparam int SRC_PHASE = 1;
   localparam int SRC_DBG   = 2;

   // Widths of internal counters / pointer
   localparam int PTR_W  = 2;
   localparam int OCC_W  = 11;
   localparam int IDLE_W = 8;

   // Source index following the (one-hot) winner, wrapping debug -> ADC.
   function automatic logic [PTR_W-1:0] src_after(input logic [N_SRC-1:0] gnt);
      logic [PTR_W-1:0] nxt;
      nxt = PTR_W'(SRC_ADC);
      if (gnt[SRC_DBG]) begin
         nxt = PTR_W'(SRC_ADC);
      end else if (gnt[SRC_PHASE]) begin
         nxt = PTR_W'(SRC_DBG);
      end else if (gnt[SRC_ADC]) begin
         nxt = PTR_W'(SRC_PHASE);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/usb_fifo_arbiter_arb_pick.sv
// Combinational winner selection for the packet arbiter.
// Optional feature macro: USB_ARB_RR_EN (round-robin search starting at
// ptr_i). Without it the pick is fixed priority debug > phase > ADC and the
// pointer input is ignored.
module arb_pick
   import usb_arb_pkg::*;
(
   input  logic [N_SRC-1:0] req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N_SRC-1:0] gnt_o
);

`ifdef USB_ARB_RR_EN
   logic [2:0]       idx_sum;
   logic [PTR_W-1:0] idx;
   logic             found;

   // Scan sources starting at the pointer and take the first requester
   always_comb begin
      gnt_o   = '0;
      found   = 1'b0;
      idx_sum = '0;
      idx     = '0;
      for (int k = 0; k < N_SRC; k++) begin
         idx_sum = {1'b0, ptr_i} + 3'(k);
         if (idx_sum >= 3'(N_SRC)) begin
            idx_sum = idx_sum - 3'(N_SRC);
         end
         idx = idx_sum[PTR_W-1:0];
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end
`else
   logic unused_ptr;
   assign unused_ptr = ^ptr_i;

   // Fixed priority: debug packets first, then phase, then ADC
   always_comb begin
      gnt_o = '0;
      if (req_i[SRC_DBG]) begin
         gnt_o[SRC_DBG] = 1'b1;
      end else if (req_i[SRC_PHASE]) begin
         gnt_o[SRC_PHASE] = 1'b1;
      end else if (req_i[SRC_ADC]) begin
         gnt_o[SRC_ADC] = 1'b1;
      end
   end
`endif

endmodule

// File: rtl/usb_fifo_arbiter.sv
// Packet-level arbiter sharing the 8-bit USB TX FIFO write port between the
// ADC, phase and debug byte streams. A whole packet is granted at a time,
// MAX_PKT bytes of FIFO space are reserved before each grant using an
// internal occupancy counter, and a granted source that stalls for TIMEOUT
// cycles loses its grant.
// Optional feature macro: USB_ARB_RR_EN (round-robin instead of fixed
// priority; adds the rotating pointer register).
//
// Handshake: a beat moves from source g to the arbiter on a rising clk_60m
// edge where src_valid[g] & src_ready[g]; src_ready only depends on the
// registered grant/occupancy and src_valid, and each moved beat appears on
// fifo_din with fifo_wr_en high for exactly one cycle, one cycle later.
module usb_fifo_arbiter
   import usb_arb_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int MAX_PKT = 16,
   parameter int TIMEOUT = 255
)
(
   input  logic             clk_60m,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [N_SRC-1:0] src_valid,
   input  logic [7:0]       src_data0,
   input  logic [7:0]       src_data1,
   input  logic [7:0]       src_data2,
   input  logic [N_SRC-1:0] src_last,
   output logic [N_SRC-1:0] src_ready,
   output logic [7:0]       fifo_din,
   output logic             fifo_wr_en,
   input  logic             fifo_full,
   input  logic             fifo_rd_en,
   output logic [N_SRC-1:0] grant,
   output logic [OCC_W-1:0] occupancy,
   input  logic             err_clr,
   output logic             err_timeout,
   output logic             err_full,
   output logic             state_dbg_o
);

   localparam logic [OCC_W-1:0]  DEPTH_L   = OCC_W'(DEPTH);
   localparam logic [OCC_W-1:0]  MAX_PKT_L = OCC_W'(MAX_PKT);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

   arb_state_e        state_q, state_d;
   logic [N_SRC-1:0]  grant_q, grant_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic [7:0]        din_q, din_d;
   logic              wr_q, wr_d;
   logic              err_to_q, err_to_d;
   logic              err_full_q, err_full_d;

   logic [OCC_W-1:0]  free_space;
   logic              free_ok;
   logic              space_ok;
   logic              arb_start;
   logic [N_SRC-1:0]  ready;
   logic              accept;
   logic              sel_last;
   logic [7:0]        sel_data;
   logic [N_SRC-1:0]  pick_gnt;
   logic [PTR_W-1:0]  rr_ptr;
   logic              to_hit;
   logic              occ_dec;

   // Space checks, per-source ready and the granted source's beat
   always_comb begin
      free_space = DEPTH_L - occ_q;
      free_ok    = (free_space >= MAX_PKT_L);
      space_ok   = (occ_q < DEPTH_L);
      arb_start  = (state_q == IDLE) && enable && (|src_valid) && free_ok;
      ready      = '0;
      if (state_q == BUSY) begin
         ready = grant_q & src_valid & {N_SRC{space_ok}};
      end
      accept   = |ready;
      sel_last = |(grant_q & src_last);
      sel_data = ({8{grant_q[SRC_ADC]}}   & src_data0) |
                 ({8{grant_q[SRC_PHASE]}} & src_data1) |
                 ({8{grant_q[SRC_DBG]}}   & src_data2);
   end

   arb_pick u_pick (
      .req_i (src_valid),
      .ptr_i (rr_ptr),
      .gnt_o (pick_gnt)
   );

`ifdef USB_ARB_RR_EN
   logic [PTR_W-1:0] ptr_q, ptr_d;

   // Pointer advances past each new winner
   always_comb begin
      ptr_d = ptr_q;
      if (arb_start) begin
         ptr_d = src_after(pick_gnt);
      end
   end

   // Round-robin pointer register, starts at ADC
   always_ff @(posedge clk_60m or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= PTR_W'(SRC_ADC);
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign rr_ptr = ptr_q;
`else
   assign rr_ptr = PTR_W'(SRC_ADC);
`endif

   // FSM next state: grant whole packets, release on last beat or stall timeout
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idle_d  = idle_q;
      to_hit  = 1'b0;
      case (state_q)
         IDLE: begin
            idle_d = '0;
            if (arb_start) begin
               grant_d = pick_gnt;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (accept) begin
               idle_d = '0;
               if (sel_last) begin
                  grant_d = '0;
                  state_d = IDLE;
               end
            end else if (idle_q == IDLE_LAST) begin
               idle_d  = '0;
               grant_d = '0;
               to_hit  = 1'b1;
               state_d = IDLE;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            idle_d  = '0;
         end
      endcase
   end

   // Write register, occupancy tracking and sticky error flags
   always_comb begin
      wr_d       = accept;
      din_d      = accept ? sel_data : din_q;
      occ_dec    = fifo_rd_en && (occ_q != '0);
      occ_d      = occ_q;
      err_to_d   = err_to_q;
      err_full_d = err_full_q;
      if (accept && !occ_dec) begin
         occ_d = occ_q + 1'b1;
      end else if (!accept && occ_dec) begin
         occ_d = occ_q - 1'b1;
      end
      if (err_clr) begin
         err_to_d = 1'b0;
      end else if (to_hit) begin
         err_to_d = 1'b1;
      end
      if (err_clr) begin
         err_full_d = 1'b0;
      end else if (wr_q && fifo_full) begin
         err_full_d = 1'b1;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk_60m or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         idle_q     <= '0;
         occ_q      <= '0;
         din_q      <= '0;
         wr_q       <= 1'b0;
         err_to_q   <= 1'b0;
         err_full_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         idle_q     <= idle_d;
         occ_q      <= occ_d;
         din_q      <= din_d;
         wr_q       <= wr_d;
         err_to_q   <= err_to_d;
         err_full_q <= err_full_d;
      end
   end

   assign src_ready   = ready;
   assign fifo_din    = din_q;
   assign fifo_wr_en  = wr_q;
   assign grant       = grant_q;
   assign occupancy   = occ_q;
   assign err_timeout = err_to_q;
   assign err_full    = err_full_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_usb_fifo_arbiter.sv
// Self-checking bench for usb_fifo_arbiter: packet drivers per source, a byte
// scoreboard and a grant-order scoreboard filled from a small arbitration
// model, plus directed checks on occupancy, timeout and error flags.
module tb_usb_fifo_arbiter;

   localparam int BOUND = 400;

   logic       clk_60m = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       v [3];
   logic       l [3];
   logic [7:0] d [3];
   logic [2:0] src_valid;
   logic [2:0] src_last;
   logic [2:0] src_ready;
   logic [7:0] fifo_din;
   logic       fifo_wr_en;
   logic       fifo_full;
   logic       fifo_rd_en;
   logic [2:0] grant;
   logic [10:0] occupancy;
   logic       err_clr;
   logic       err_timeout;
   logic       err_full;
   logic       state_dbg;

   logic [7:0] exp_q[$];
   logic [2:0] exp_gnt_q[$];
   logic [2:0] gnt_prev;
   int         tb_ptr;
   int         tb_occ;
   int         n_checks;
   int         n_fail;

   assign src_valid = {v[2], v[1], v[0]};
   assign src_last  = {l[2], l[1], l[0]};

   usb_fifo_arbiter dut (
      .clk_60m     (clk_60m),
      .rst_n       (rst_n),
      .enable      (enable),
      .src_valid   (src_valid),
      .src_data0   (d[0]),
      .src_data1   (d[1]),
      .src_data2   (d[2]),
      .src_last    (src_last),
      .src_ready   (src_ready),
      .fifo_din    (fifo_din),
      .fifo_wr_en  (fifo_wr_en),
      .fifo_full   (fifo_full),
      .fifo_rd_en  (fifo_rd_en),
      .grant       (grant),
      .occupancy   (occupancy),
      .err_clr     (err_clr),
      .err_timeout (err_timeout),
      .err_full    (err_full),
      .state_dbg_o (state_dbg)
   );

   // Clock
   initial forever #8 clk_60m = ~clk_60m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Arbitration model used to predict grant order
   function automatic int model_pick(input logic [2:0] req);
      int r;
      r = -1;
`ifdef USB_ARB_RR_EN
      for (int i = 0; i < 3; i++) begin
         int s;
         s = (tb_ptr + i) % 3;
         if (r < 0 && req[s]) r = s;
      end
`else
      for (int s = 2; s >= 0; s--) begin
         if (r < 0 && req[s]) r = s;
      end
`endif
      return r;
   endfunction

   function automatic logic [7:0] pkt_byte(input int s, input int k, input int b,
                                           input int len, input int base);
      return 8'(base + s * 64 + k * len + b);
   endfunction

   task automatic expect_grant(input int s);
      exp_gnt_q.push_back(3'(1 << s));
      tb_ptr = (s + 1) % 3;
   endtask

   task automatic expect_byte(input logic [7:0] b);
      exp_q.push_back(b);
      tb_occ++;
   endtask

   // One beat: present it and wait (bounded) for the handshake edge
   task automatic send_beat(input int s, input logic [7:0] data, input logic last);
      int n;
      v[s] = 1'b1;
      d[s] = data;
      l[s] = last;
      n = 0;
      @(negedge clk_60m);
      while (!src_ready[s] && n < BOUND) begin
         n++;
         @(negedge clk_60m);
      end
      if (!src_ready[s]) check("handshake_wait", 32'(src_ready), 32'(1 << s));
      @(posedge clk_60m);
      #1;
   endtask

   task automatic drive_pkt(input int s, input int len, input logic [7:0] base);
      for (int b = 0; b < len; b++) begin
         send_beat(s, 8'(base + 8'(b)), (b == len - 1));
      end
      v[s] = 1'b0;
      l[s] = 1'b0;
   endtask

   task automatic rd_pulses(input int n);
      if (n > 0) begin
         fifo_rd_en = 1'b1;
         repeat (n) @(posedge clk_60m);
         #1;
         fifo_rd_en = 1'b0;
         tb_occ = (tb_occ > n) ? tb_occ - n : 0;
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk_60m);
      #1;
   endtask

   // All three sources present npkt packets of len bytes at once
   task automatic run_multi(input int npkt, input int len, input int base);
      int rem [3];
      int cnt [3];
      int s;
      logic [2:0] req;
      for (int i = 0; i < 3; i++) begin
         rem[i] = npkt;
         cnt[i] = 0;
      end
      while (rem[0] + rem[1] + rem[2] > 0) begin
         req = {rem[2] > 0, rem[1] > 0, rem[0] > 0};
         s = model_pick(req);
         expect_grant(s);
         for (int b = 0; b < len; b++) expect_byte(pkt_byte(s, cnt[s], b, len, base));
         cnt[s]++;
         rem[s]--;
      end
      fork
         for (int k = 0; k < npkt; k++) drive_pkt(0, len, pkt_byte(0, k, 0, len, base));
         for (int k = 0; k < npkt; k++) drive_pkt(1, len, pkt_byte(1, k, 0, len, base));
         for (int k = 0; k < npkt; k++) drive_pkt(2, len, pkt_byte(2, k, 0, len, base));
      join
   endtask

   // Byte scoreboard: every FIFO write must match the next expected byte
   always @(negedge clk_60m) begin
      if (rst_n && fifo_wr_en) begin
         if (exp_q.size() == 0) check("unexpected_write", 32'(fifo_din), 32'hFFFF_FFFF);
         else check("fifo_din", 32'(fifo_din), 32'(exp_q.pop_front()));
      end
   end

   // Grant scoreboard: every new grant must be one-hot and in predicted order
   always @(negedge clk_60m) begin
      if (rst_n && grant != 3'b000 && gnt_prev == 3'b000) begin
         if (exp_gnt_q.size() == 0) check("unexpected_grant", 32'(grant), 32'h0);
         else check("grant_order", 32'(grant), 32'(exp_gnt_q.pop_front()));
      end
      gnt_prev = grant;
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      tb_ptr     = 0;
      tb_occ     = 0;
      gnt_prev   = '0;
      rst_n      = 1'b0;
      enable     = 1'b1;
      fifo_full  = 1'b0;
      fifo_rd_en = 1'b0;
      err_clr    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         v[i] = 1'b0;
         l[i] = 1'b0;
         d[i] = 8'h00;
      end

      // Reset state
      cycles(3);
      @(negedge clk_60m);
      check("rst_grant", 32'(grant), 0);
      check("rst_ready", 32'(src_ready), 0);
      check("rst_wr_en", 32'(fifo_wr_en), 0);
      check("rst_din", 32'(fifo_din), 0);
      check("rst_occ", 32'(occupancy), 0);
      check("rst_errs", 32'({err_timeout, err_full}), 0);
      check("rst_state", 32'(state_dbg), 0);
      rst_n = 1'b1;
      cycles(2);

      // Single ADC packet A5, 5A
      expect_grant(0);
      expect_byte(8'hA5);
      expect_byte(8'h5A);
      fork
         begin
            send_beat(0, 8'hA5, 1'b0);
            send_beat(0, 8'h5A, 1'b1);
            v[0] = 1'b0;
            l[0] = 1'b0;
         end
         begin
            @(negedge clk_60m);
            check("grant_before_edge", 32'(grant), 0);
            @(negedge clk_60m);
            check("grant_latency", 32'(grant), 32'b001);
         end
      join
      @(negedge clk_60m);
      check("adc_pkt_grant_clear", 32'(grant), 0);
      check("adc_pkt_occ", 32'(occupancy), 2);
      check("adc_pkt_state", 32'(state_dbg), 0);
      cycles(2);

      // All three valid: packets must not interleave and follow priority
      run_multi(1, 3, 8'h10);
      cycles(3);
      // Continuously valid 1-byte packets
      run_multi(2, 1, 8'h80);
      cycles(3);
      check("multi_occ", 32'(occupancy), 32'(tb_occ));

      // Enable low: nothing granted until it returns
      enable = 1'b0;
      expect_grant(0);
      expect_byte(8'h55);
      fork
         drive_pkt(0, 1, 8'h55);
         begin
            repeat (10) @(negedge clk_60m);
            check("enable_low_no_grant", 32'(grant), 0);
            enable = 1'b1;
         end
      join
      cycles(3);

      // Phase source stalls mid-packet until timeout
      expect_grant(1);
      expect_byte(8'h11);
      send_beat(1, 8'h11, 1'b0);
      v[1] = 1'b0;
      repeat (254) @(posedge clk_60m);
      @(negedge clk_60m);
      check("busy_before_timeout", 32'(grant), 32'b010);
      check("no_timeout_yet", 32'(err_timeout), 0);
      @(posedge clk_60m);
      @(negedge clk_60m);
      check("timeout_grant", 32'(grant), 0);
      check("timeout_flag", 32'(err_timeout), 1);
      check("timeout_occ", 32'(occupancy), 32'(tb_occ));
      cycles(5);
      check("timeout_sticky", 32'(err_timeout), 1);
      err_clr = 1'b1;
      cycles(1);
      err_clr = 1'b0;
      check("timeout_cleared", 32'(err_timeout), 0);

      // Occupancy: simultaneous accept and read at 5, then reads at 0
      rd_pulses(tb_occ - 5);
      check("occ_drained_to_5", 32'(occupancy), 5);
      expect_grant(0);
      expect_byte(8'h77);
      v[0] = 1'b1;
      d[0] = 8'h77;
      l[0] = 1'b1;
      begin
         int n;
         n = 0;
         @(negedge clk_60m);
         while (!src_ready[0] && n < BOUND) begin
            n++;
            @(negedge clk_60m);
         end
         check("simul_ready", 32'(src_ready[0]), 1);
      end
      fifo_rd_en = 1'b1;
      @(posedge clk_60m);
      #1;
      fifo_rd_en = 1'b0;
      v[0] = 1'b0;
      l[0] = 1'b0;
      tb_occ--;
      check("occ_simul", 32'(occupancy), 5);
      rd_pulses(5);
      check("occ_zero", 32'(occupancy), 0);
      rd_pulses(2);
      check("occ_saturate", 32'(occupancy), 0);

      // err_full: set by a write while full, cleared with priority over set
      fifo_full = 1'b1;
      expect_grant(0);
      expect_byte(8'hE1);
      drive_pkt(0, 1, 8'hE1);
      cycles(1);
      fifo_full = 1'b0;
      check("err_full_set", 32'(err_full), 1);
      cycles(3);
      check("err_full_sticky", 32'(err_full), 1);
      err_clr   = 1'b1;
      fifo_full = 1'b1;
      expect_grant(0);
      expect_byte(8'hE2);
      drive_pkt(0, 1, 8'hE2);
      cycles(1);
      check("err_clr_priority", 32'(err_full), 0);
      err_clr   = 1'b0;
      fifo_full = 1'b0;
      cycles(2);
      check("err_full_stays_clear", 32'(err_full), 0);

      // Reset asserted mid-packet
      expect_grant(0);
      expect_byte(8'h31);
      send_beat(0, 8'h31, 1'b0);
      v[0] = 1'b0;
      cycles(2);
      rst_n = 1'b0;
      #1;
      check("midrst_grant", 32'(grant), 0);
      check("midrst_occ", 32'(occupancy), 0);
      check("midrst_state", 32'(state_dbg), 0);
      tb_occ = 0;
      tb_ptr = 0;
      cycles(2);
      rst_n = 1'b1;
      cycles(2);

      // Fill to DEPTH-15: no grant until one byte is read out
      for (int p = 0; p < 63; p++) begin
         expect_grant(0);
         for (int b = 0; b < 16; b++) expect_byte(8'(p * 16 + b));
         drive_pkt(0, 16, 8'(p * 16));
      end
      expect_grant(0);
      expect_byte(8'hC3);
      drive_pkt(0, 1, 8'hC3);
      cycles(2);
      check("fill_occ", 32'(occupancy), 1009);
      check("fill_model_occ", 32'(occupancy), 32'(tb_occ));
      expect_grant(2);
      expect_byte(8'hD0);
      fork
         drive_pkt(2, 1, 8'hD0);
         begin
            repeat (5) @(negedge clk_60m);
            check("full_no_grant", 32'(grant), 0);
            @(posedge clk_60m);
            #1;
            fifo_rd_en = 1'b1;
            @(posedge clk_60m);
            #1;
            fifo_rd_en = 1'b0;
            @(negedge clk_60m);
            check("after_rd_occ", 32'(occupancy), 1008);
            check("after_rd_still_idle", 32'(grant), 0);
            @(negedge clk_60m);
            check("grant_after_rd", 32'(grant), 32'b100);
         end
      join
      cycles(3);
      check("final_occ", 32'(occupancy), 1009);

      check("byte_sb_empty", 32'(exp_q.size()), 0);
      check("grant_sb_empty", 32'(exp_gnt_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/usb_fifo_arbiter.md
# usb_fifo_arbiter

Packet-level arbiter sharing the single 8-bit USB TX FIFO write port between three byte-stream sources: ADC sample stream, phase stream and debug packets. Grants whole packets so streams never interleave mid-packet, reserves FIFO space before each packet via an internal occupancy counter, and times out stalled sources. Sits between the per-source serialisers and the 1024×8 common-clock FIFO in the 60 MHz domain.

## Interface
- DEPTH, 1024, FIFO depth in bytes
- MAX_PKT, 16, longest packet in bytes; a grant requires this much free space
- TIMEOUT, 255, max consecutive idle cycles inside a granted packet before abort
- clk_60m  in  1  60 MHz clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  1 = arbitration allowed; 0 = finish current packet, then grant nothing
- src_valid  in  3  per-source byte valid (0=ADC, 1=phase, 2=debug)
- src_data0 / src_data1 / src_data2  in  8 each  per-source byte
- src_last  in  3  per-source last byte of packet
- src_ready  out  3  per-source accept; beat transfers when valid & ready
- fifo_din  out  8  FIFO write data
- fifo_wr_en  out  1  FIFO write enable
- fifo_full  in  1  FIFO full flag
- fifo_rd_en  in  1  FIFO read strobe from USB TX (tracked for occupancy)
- grant  out  3  one-hot current owner, 0 when idle
- occupancy  out  11  bytes accepted and not yet read, 0..DEPTH
- err_clr  in  1  clears sticky error flags
- err_timeout  out  1  sticky: packet aborted by timeout
- err_full  out  1  sticky: fifo_full seen while fifo_wr_en high

## Operation
- States: IDLE, BUSY.
- IDLE: if enable and any src_valid and (DEPTH − occupancy) ≥ MAX_PKT → pick a winner, load grant, go BUSY. Otherwise stay.
- Pick: fixed priority debug > phase > ADC (see Configuration).
- BUSY: src_ready[g] = src_valid[g] & (occupancy < DEPTH); other ready bits 0. Each accepted beat registers into fifo_din/fifo_wr_en. Accepted beat with src_last → IDLE, grant cleared the same edge.
- Timeout: idle counter (8 bit) counts BUSY cycles with no accepted beat; resets on accept. Reaching TIMEOUT → IDLE, err_timeout set, partial packet remains in FIFO.
- Occupancy: +1 on accepted beat, −1 on fifo_rd_en when occupancy > 0; both same cycle → unchanged; rd_en at 0 ignored (saturate).
- err_full: set when fifo_wr_en & fifo_full; write still issued (FIFO drops it). err_clr has priority over set in the same cycle.
- enable falling in BUSY has no effect until packet ends.

## Timing
- Reset: state IDLE, grant 0, src_ready 0, fifo_wr_en 0, fifo_din 0, occupancy 0, idle counter 0, errors 0, RR pointer at ADC.
- Grant latency: src_valid seen in IDLE at edge N → grant and first possible src_ready at N+1.
- src_ready is combinational from registered grant/occupancy and src_valid.
- Accept → fifo_wr_en/fifo_din: 1 cycle; fifo_wr_en high exactly one cycle per byte.
- Back-to-back packets: ≥1 IDLE cycle between packets (arbitration cycle); 1-byte packets: max 1 byte / 2 cycles.
- Reset asserted mid-packet: all state cleared immediately; partial packet is not replayed.

## Configuration
- USB_ARB_RR_EN defined: round-robin; pointer moves to source after the last winner on each grant; search order starts at pointer.
- Undefined: fixed priority debug > phase > ADC; no pointer register.

## Structure
- Package usb_arb_pkg: state encoding (IDLE, BUSY), source indices SRC_ADC=0, SRC_PHASE=1, SRC_DBG=2, N_SRC=3.
- Sub-module arb_pick: combinational request vector + pointer → one-hot winner; both priority modes inside it.

## Test plan
- Single ADC packet of 2 bytes (0xA5, 0x5A, last on second) → grant=001 next cycle, fifo_din 0xA5 then 0x5A, occupancy 2, grant 0 after last.
- All three valid in IDLE, fixed priority → debug packet first, then phase, then ADC; no byte interleaving.
- With USB_ARB_RR_EN, all three continuously valid with 1-byte packets → grant order 001,010,100,001…
- Occupancy preloaded to 1009 (DEPTH−15) with no reads → no grant; one fifo_rd_en → grant next cycle.
- Granted phase source drops valid for 255 cycles mid-packet → return to IDLE, err_timeout=1, held until err_clr.
- Simultaneous accept and fifo_rd_en at occupancy 5 → stays 5; fifo_rd_en at 0 → stays 0.
